// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: opcodes, ALU encodings and sequencer states                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [5:0] OP_ADD    = 6'b010000;
    localparam logic [5:0] OP_ADDI   = 6'b110000;
    localparam logic [5:0] OP_SUBI   = 6'b111000;
    localparam logic [5:0] OP_SHIFTL = 6'b100000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_SHL  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_PCUPD  = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | opcode_decoder: combinational IR -> ALU controls and instruction class|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [1:0]  alu_op_o,
    output logic        alu_src_imm_o,
    output logic        writes_reg_o,
    output logic        dest_rd_o,
    output logic        is_jump_o,
    output logic        is_branch_o,
    output logic        is_nop_o,
    output logic        illegal_o
);

    always_comb begin
        alu_op_o      = ALU_PASS;
        alu_src_imm_o = 1'b0;
        writes_reg_o  = 1'b0;
        dest_rd_o     = 1'b0;
        is_jump_o     = 1'b0;
        is_branch_o   = 1'b0;
        is_nop_o      = 1'b0;
        illegal_o     = 1'b0;
        case (ir_i[31:26])
            OP_ADD: begin
                alu_op_o     = ALU_ADD;
                writes_reg_o = 1'b1;
                dest_rd_o    = 1'b1;
            end
            OP_ADDI: begin
                alu_op_o      = ALU_ADD;
                alu_src_imm_o = 1'b1;
                writes_reg_o  = 1'b1;
            end
            OP_SUBI: begin
                alu_op_o      = ALU_SUB;
                alu_src_imm_o = 1'b1;
                writes_reg_o  = 1'b1;
            end
            OP_SHIFTL: begin
                alu_op_o     = ALU_SHL;
                writes_reg_o = 1'b1;
                dest_rd_o    = 1'b1;
            end
            OP_J:    is_jump_o   = 1'b1;
            OP_BEQ:  is_branch_o = 1'b1;
            // Only the all-zero word is a NOP; opcode 0 with payload is illegal.
            default: begin
                if (ir_i == 32'd0) is_nop_o  = 1'b1;
                else               illegal_o = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_sequencer: multi-cycle fetch/decode/exec/wb/pc-update controller |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_DEPTH = 21,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instruction,
    input  logic              operands_equal,
    output logic              control,
    output logic [ADDR_W-1:0] next_pc_address,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [4:0]        rd_addr,
    output logic [15:0]       imm,
    output logic [1:0]        alu_op,
    output logic              alu_src_imm,
    output logic              reg_write,
    output logic              halted,
    output logic              illegal,
    output logic [15:0]       retired
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        taken_q, taken_d;
    logic        illegal_q, illegal_d;
    logic [15:0] retired_q, retired_d;

    logic        dec_writes_reg, dec_dest_rd, dec_is_jump, dec_is_branch;
    logic        dec_is_nop, dec_illegal, redirect;
    logic [4:0]  dest_idx;
    logic [ADDR_W-1:0] target;

    opcode_decoder u_dec (
        .ir_i          (ir_q),
        .alu_op_o      (alu_op),
        .alu_src_imm_o (alu_src_imm),
        .writes_reg_o  (dec_writes_reg),
        .dest_rd_o     (dec_dest_rd),
        .is_jump_o     (dec_is_jump),
        .is_branch_o   (dec_is_branch),
        .is_nop_o      (dec_is_nop),
        .illegal_o     (dec_illegal)
    );

    assign rs_addr  = ir_q[25:21];
    assign rt_addr  = ir_q[20:16];
    assign rd_addr  = ir_q[15:11];
    assign imm      = ir_q[15:0];
    assign dest_idx = dec_dest_rd ? ir_q[15:11] : ir_q[20:16];
    assign target   = ir_q[ADDR_W-1:0];
    assign redirect = dec_is_jump | (dec_is_branch & taken_q);
    assign halted   = (state_q == ST_HALT);
    assign illegal  = illegal_q;
    assign retired  = retired_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ir_d            = ir_q;
        taken_d         = taken_q;
        illegal_d       = illegal_q;
        retired_d       = retired_q;
        control         = 1'b0;
        next_pc_address = '0;
        reg_write       = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                control         = 1'b1;
                next_pc_address = pc;
                ir_d            = instruction;
                state_d         = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                taken_d = dec_is_branch & operands_equal;
                state_d = (dec_is_jump | dec_is_branch | dec_is_nop) ? ST_PCUPD : ST_WB;
            end
            ST_WB: begin
                reg_write = dec_writes_reg & (dest_idx != 5'd0);
                state_d   = ST_PCUPD;
            end
            ST_PCUPD: begin
                // An out-of-range target is treated as a fault: nothing retires.
                if (redirect && (target > LAST_PC)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (redirect) begin
                    control         = 1'b1;
                    next_pc_address = target;
                    retired_d       = sat_inc16(retired_q);
                    state_d         = ST_FETCH;
                end else if (pc == LAST_PC) begin
                    retired_d = sat_inc16(retired_q);
                    state_d   = ST_HALT;
                end else begin
                    control         = 1'b1;
                    next_pc_address = pc + ADDR_W'(1);
                    retired_d       = sat_inc16(retired_q);
                    state_d         = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_sequencer: instruction-level model vs cpu_sequencer           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  pc;
    logic [31:0] instruction;
    logic        operands_equal;
    logic        control;
    logic [4:0]  next_pc_address;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [15:0] imm;
    logic [1:0]  alu_op;
    logic        alu_src_imm, reg_write, halted, illegal;
    logic [15:0] retired;

    logic [31:0] mem [32];
    int n_assert = 0;
    int n_fail   = 0;
    int mpc, mret;
    bit mhalt, mill;

    cpu_sequencer #(.MEM_DEPTH(21), .ADDR_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .pc              (pc),
        .instruction     (instruction),
        .operands_equal  (operands_equal),
        .control         (control),
        .next_pc_address (next_pc_address),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rd_addr         (rd_addr),
        .imm             (imm),
        .alu_op          (alu_op),
        .alu_src_imm     (alu_src_imm),
        .reg_write       (reg_write),
        .halted          (halted),
        .illegal         (illegal),
        .retired         (retired)
    );

    always #5 clk = ~clk;

    // Fetch unit: PC register plus instruction memory.
    always @(posedge clk or negedge reset) begin
        if (!reset)       pc <= 5'd0;
        else if (control) pc <= next_pc_address;
    end
    assign instruction = mem[pc];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        operands_equal = 1'b0;
        step();
        step();
        reset = 1'b1;
        mpc = 0; mret = 0; mhalt = 1'b0; mill = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: return {6'b010000, r[25:11], 11'd0};
            1: return {6'b110000, r[25:0]};
            2: return {6'b111000, r[25:0]};
            3: return {6'b100000, r[25:11], 11'd0};
            4: return {6'b000010, r[25:5], 5'($urandom_range(0, 23))};
            5: return {6'b000100, r[25:5], 5'($urandom_range(0, 20))};
            default: return 32'd0;
        endcase
    endfunction

    // Precondition: DUT is in its fetch cycle for the instruction at mpc.
    task automatic run_instr(input bit eq);
        logic [31:0] w;
        logic [5:0]  op;
        bit   is_alu, rtype, bad, jump;
        int   dest, exp_alu, tgt, nw, ncyc;
        w      = mem[mpc];
        op     = w[31:26];
        is_alu = (op == 6'b010000) || (op == 6'b110000) || (op == 6'b111000) || (op == 6'b100000);
        rtype  = (op == 6'b010000) || (op == 6'b100000);
        bad    = !(is_alu || op == 6'b000010 || op == 6'b000100 || w == 32'd0);
        dest   = rtype ? int'(w[15:11]) : int'(w[20:16]);
        exp_alu = (op == 6'b010000 || op == 6'b110000) ? 0 :
                  (op == 6'b111000) ? 1 : (op == 6'b100000) ? 2 : 3;
        jump   = (op == 6'b000010) || (op == 6'b000100 && eq);
        tgt    = int'(w[4:0]);
        operands_equal = eq;

        chk("fetch_control", 32'(control), 32'd1);
        chk("fetch_npc", 32'(next_pc_address), 32'(mpc));
        if (bad) begin
            step();
            chk("decode_control", 32'(control), 32'd0);
            step();
            mhalt = 1'b1; mill = 1'b1;
            chk("bad_halted", 32'(halted), 32'd1);
            chk("bad_illegal", 32'(illegal), 32'd1);
            chk("bad_control", 32'(control), 32'd0);
            return;
        end
        ncyc = is_alu ? 5 : 4;
        nw = 0;
        for (int c = 1; c < ncyc - 1; c++) begin
            step();
            chk("mid_control", 32'(control), 32'd0);
            if (c == 2) begin
                chk("alu_op", 32'(alu_op), 32'(exp_alu));
                chk("alu_src_imm", 32'(alu_src_imm), 32'(op == 6'b110000 || op == 6'b111000));
            end
            if (reg_write) begin
                nw++;
                chk("wr_dest", rtype ? 32'(rd_addr) : 32'(rt_addr), 32'(dest));
                chk("wr_imm", 32'(imm), 32'(w[15:0]));
            end
        end
        chk("write_count", 32'(nw), 32'(is_alu && dest != 0));

        step();
        if (jump && tgt > 20) begin
            chk("pcupd_badtgt_control", 32'(control), 32'd0);
            mhalt = 1'b1; mill = 1'b1;
        end else if (jump) begin
            chk("pcupd_jump_control", 32'(control), 32'd1);
            chk("pcupd_jump_npc", 32'(next_pc_address), 32'(tgt));
            mret++; mpc = tgt;
        end else if (mpc == 20) begin
            chk("pcupd_last_control", 32'(control), 32'd0);
            mret++; mhalt = 1'b1;
        end else begin
            chk("pcupd_seq_control", 32'(control), 32'd1);
            chk("pcupd_seq_npc", 32'(next_pc_address), 32'(mpc + 1));
            mret++; mpc = mpc + 1;
        end
        step();
        chk("halted", 32'(halted), 32'(mhalt));
        chk("illegal", 32'(illegal), 32'(mill));
        chk("retired", 32'(retired), 32'(mret));
    endtask

    task automatic run_program(input int max_instr, input bit rand_eq);
        int n;
        n = 0;
        start = 1'b1;
        step();
        while (!mhalt && n < max_instr) begin
            run_instr(rand_eq ? bit'($urandom_range(0, 1)) : bit'(mpc == 12));
            n++;
        end
    endtask

    task automatic check_absorbing();
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_hold_halted", 32'(halted), 32'd1);
            chk("halt_hold_control", 32'(control), 32'd0);
        end
    endtask

    initial begin
        clear_mem();
        reset = 1'b0;
        start = 1'b0;
        operands_equal = 1'b0;
        #1;
        chk("rst_control", 32'(control), 32'd0);
        chk("rst_npc", 32'(next_pc_address), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_imm", 32'(imm), 32'd0);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            chk("idle_control", 32'(control), 32'd0);
        end

        // Directed program: ALU ops, r0 destination, branches both ways, jumps, NOP, bad target.
        mem[0]  = {6'b110000, 5'd0, 5'd10, 16'd10};
        mem[1]  = {6'b110000, 5'd3, 5'd0, 16'd7};
        mem[2]  = {6'b000100, 5'd4, 5'd5, 16'd6};
        mem[3]  = {6'b000010, 26'd5};
        mem[5]  = {6'b000010, 26'd12};
        mem[12] = {6'b000100, 5'd4, 5'd5, 16'd6};
        mem[6]  = {6'b010000, 5'd2, 5'd3, 5'd1, 11'd0};
        mem[7]  = {6'b100000, 5'd1, 5'd0, 5'd7, 11'd0};
        mem[8]  = {6'b111000, 5'd1, 5'd9, 16'h1234};
        mem[9]  = 32'd0;
        mem[10] = {6'b000010, 26'd25};
        run_program(20, 1'b0);
        chk("progA_retired", 32'(retired), 32'd10);
        check_absorbing();

        // Last-word halt after a jump into the top of memory.
        do_reset();
        clear_mem();
        mem[0]  = {6'b000010, 26'd20};
        mem[20] = {6'b110000, 5'd1, 5'd3, 16'd4};
        run_program(5, 1'b0);
        chk("progC_retired", 32'(retired), 32'd2);
        chk("progC_pc_held", 32'(pc), 32'd20);
        check_absorbing();

        // Unknown opcode.
        do_reset();
        clear_mem();
        mem[0] = {6'b111111, 26'd0};
        run_program(3, 1'b0);
        check_absorbing();

        // Reset asserted during write-back.
        do_reset();
        clear_mem();
        mem[0] = {6'b110000, 5'd0, 5'd10, 16'd10};
        start = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("wb_reg_write", 32'(reg_write), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_reg_write", 32'(reg_write), 32'd0);
        chk("midrst_control", 32'(control), 32'd0);
        chk("midrst_npc", 32'(next_pc_address), 32'd0);
        chk("midrst_retired", 32'(retired), 32'd0);
        start = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_control", 32'(control), 32'd0);
            chk("postrst_reg_write", 32'(reg_write), 32'd0);
        end
        mpc = 0; mret = 0; mhalt = 1'b0; mill = 1'b0;
        run_program(2, 1'b0);

        // Randomized programs.
        for (int p = 0; p < 4; p++) begin
            do_reset();
            for (int i = 0; i < 32; i++) mem[i] = rand_word();
            run_program(40, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter MEM_DEPTH, default 21, number of instruction words; last valid PC is MEM_DEPTH-1.
REQ-002 Parameter ADDR_W, default 5, PC width.
REQ-003 Port clk  input  1  sole clock, all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 Port start  input  1  level; begins execution from IDLE.
REQ-006 Port pc  input  ADDR_W  current PC from fetch unit.
REQ-007 Port instruction  input  32  fetched word, valid only while control=1.
REQ-008 Port operands_equal  input  1  datapath compare of rs/rt values, valid in EXEC.
REQ-009 Port control  output  1  fetch enable; PC loads next_pc_address on the edge it is high.
REQ-010 Port next_pc_address  output  ADDR_W  PC value loaded when control=1.
REQ-011 Port rs_addr, rt_addr, rd_addr  output  5 each  register indices from IR.
REQ-012 Port imm  output  16  IR[15:0].
REQ-013 Port alu_op  output  2  00 add, 01 sub, 10 shift-left, 11 pass.
REQ-014 Port alu_src_imm  output  1  ALU B operand is imm.
REQ-015 Port reg_write  output  1  one-cycle register-file write strobe.
REQ-016 Port halted  output  1  in HALT state.
REQ-017 Port illegal  output  1  sticky; unknown opcode seen.
REQ-018 Port retired  output  16  instructions completed, saturating.

Function
REQ-019 FSM states: IDLE, FETCH, DECODE, EXEC, WB, PCUPD, HALT; one state per cycle.
REQ-020 IDLE -> FETCH when start=1, else stay.
REQ-021 FETCH: control=1, next_pc_address=pc (PC held), IR<=instruction; -> DECODE.
REQ-022 DECODE: opcode IR[31:26]; ADD 010000 (rd=IR[15:11]), ADDI 110000, SUBI 111000, SHIFTL 100000 (rd=IR[15:11]), J 000010, BEQ 000100, NOP all-zero word; I-type rt=IR[20:16] is destination; -> EXEC; unknown opcode -> HALT with illegal=1.
REQ-023 EXEC: ALU controls driven; BEQ samples operands_equal into taken flag; -> WB for ALU ops, -> PCUPD for J/BEQ/NOP.
REQ-024 WB: reg_write=1 for exactly one cycle unless destination index is 0 (write suppressed); -> PCUPD.
REQ-025 PCUPD: control=1; next_pc_address = IR[ADDR_W-1:0] for J or taken BEQ (absolute target), else pc+1; retired increments; -> FETCH.
REQ-026 Halt: in PCUPD, if pc=MEM_DEPTH-1 and no jump/taken branch, control=0, PC not advanced, -> HALT; jump target >= MEM_DEPTH -> HALT, illegal=1.
REQ-027 HALT is absorbing until reset; start ignored.
REQ-028 control=0 and reg_write=0 in every state not listed above; ALU outputs hold IR-derived values.
REQ-029 retired saturates at 16'hFFFF, no wrap.
REQ-030 Instruction latency: 5 cycles ALU ops, 4 cycles J/BEQ/NOP.

Reset
REQ-031 On reset=0, immediately: state=IDLE, IR=0, control=0, next_pc_address=0, reg_write=0, halted=0, illegal=0, retired=0, taken=0.
REQ-032 Reset mid-instruction aborts it; no partial write strobe after deassertion.

Structure
REQ-033 Opcode constants, alu_op encodings and state encodings belong in shared package cpu_pkg.
REQ-034 One sub-module: opcode_decoder (combinational IR -> alu_op, alu_src_imm, writes_reg, is_jump, is_branch, is_nop, illegal).

Verification
REQ-035 start=1, word ADDI r10,r0,10 at pc0 -> FETCH..PCUPD over 5 cycles, reg_write once with rt_addr=10, imm=10, next_pc_address=1, retired=1.
REQ-036 J 12 at pc5 -> no reg_write, PCUPD drives next_pc_address=12, control=1.
REQ-037 BEQ r4,r5,6 with operands_equal=0 -> next_pc_address=pc+1; with operands_equal=1 -> 6.
REQ-038 Opcode 111111 -> HALT, illegal=1, halted=1, control stays 0 thereafter.
REQ-039 ADDI to r0 -> reg_write never asserted, PC still advances.
REQ-040 reset=0 asserted during WB -> outputs zero same cycle; after release, IDLE until start.
